branch_compare_unit: RTL

Parametrised branch-resolution unit for the ID stage of the MIPS pipeline. It compares the two register-file operands early, so a taken branch costs one bubble instead of three, and generalises plain equality to six branch conditions. It forwards from MEM, detects EX and load-use hazards and stalls ID until its operands are valid. It holds each decision stable while ID is frozen, and keeps saturating branch statistics.

---
 rtl/branch_compare_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/branch_compare_unit.sv
// branch_compare_unit
// Early branch resolution in ID. It forwards the MEM-stage ALU result and
// stalls on EX-stage writers and MEM-stage loads. Once a decision is made
// while ID is frozen, it holds that decision. It also keeps saturating
// branch statistics.
module branch_compare_unit #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_branch_valid,
  input  logic [2:0]         i_branch_op,
  input  logic               i_id_advance,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_rs_addr,
  input  logic [ADDR_W-1:0]  i_rt_addr,
  input  logic [WIDTH-1:0]   i_reg_1_content,
  input  logic [WIDTH-1:0]   i_reg_2_content,
  input  logic               i_ex_reg_write,
  input  logic [ADDR_W-1:0]  i_ex_dest,
  input  logic               i_mem_reg_write,
  input  logic               i_mem_mem_read,
  input  logic [ADDR_W-1:0]  i_mem_dest,
  input  logic [WIDTH-1:0]   i_mem_alu_result,
  output logic               o_branch_stall,
  output logic               o_branch_taken,
  output logic               o_branch_resolved,
  output logic               o_operands_equal,
  output logic [COUNT_W-1:0] o_branch_count,
  output logic [COUNT_W-1:0] o_taken_count,
  output logic [COUNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLEZ = 3'd2;
  localparam logic [2:0] OP_BGTZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;
  localparam logic [2:0] OP_BGEZ = 3'd5;

  state_t r_state;
  state_t w_next;
  logic   r_taken_held;

  // Index 0 is rs (operand A), index 1 is rt (operand B).
  logic [ADDR_W-1:0] w_src   [2];
  logic [WIDTH-1:0]  w_rf    [2];
  logic [WIDTH-1:0]  w_opnd  [2];
  logic [1:0]        w_ex_hz;
  logic [1:0]        w_ld_hz;
  logic [1:0]        w_fwd;
  logic [1:0]        w_need;
  logic              w_hazard;
  logic              w_cond;
  logic              w_latch;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;

  assign w_src[0] = i_rs_addr;
  assign w_src[1] = i_rt_addr;
  assign w_rf[0]  = i_reg_1_content;
  assign w_rf[1]  = i_reg_2_content;

  // rs feeds every condition. rt only matters for the two-operand compares.
  assign w_need = {(i_branch_op == OP_BEQ) || (i_branch_op == OP_BNE), 1'b1};

  // Per-source hazard and forwarding detection. Register 0 is hard-wired,
  // so it never waits and never forwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic w_nz;
      assign w_nz        = (w_src[gi] != '0);
      assign w_ex_hz[gi] = w_nz && i_ex_reg_write && (i_ex_dest == w_src[gi]);
      assign w_ld_hz[gi] = w_nz && i_mem_reg_write && i_mem_mem_read
                           && (i_mem_dest == w_src[gi]);
      assign w_fwd[gi]   = w_nz && i_mem_reg_write && !i_mem_mem_read
                           && (i_mem_dest == w_src[gi]);
      assign w_opnd[gi]  = w_fwd[gi] ? i_mem_alu_result : w_rf[gi];
    end
  endgenerate

  assign w_hazard         = |((w_ex_hz | w_ld_hz) & w_need);
  assign w_a              = w_opnd[0];
  assign w_b              = w_opnd[1];
  assign o_operands_equal = (w_a == w_b);

  // Branch condition on the forwarded operands. Sign tests are two's complement.
  always_comb begin
    w_cond = 1'b0;
    case (i_branch_op)
      OP_BEQ:  w_cond = (w_a == w_b);
      OP_BNE:  w_cond = (w_a != w_b);
      OP_BLEZ: w_cond = w_a[WIDTH-1] || (w_a == '0);
      OP_BGTZ: w_cond = !w_a[WIDTH-1] && (w_a != '0);
      OP_BLTZ: w_cond = w_a[WIDTH-1];
      OP_BGEZ: w_cond = !w_a[WIDTH-1];
      default: w_cond = 1'b0;
    endcase
  end

  // Next-state logic and decision outputs. Flush overrides every state.
  always_comb begin
    w_next            = r_state;
    w_latch           = 1'b0;
    o_branch_stall    = 1'b0;
    o_branch_resolved = 1'b0;
    o_branch_taken    = 1'b0;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: begin
          o_branch_stall    = i_branch_valid && w_hazard;
          o_branch_resolved = i_branch_valid && !w_hazard;
          o_branch_taken    = o_branch_resolved && w_cond;
          if (!i_branch_valid) begin
            w_next = S_IDLE;
          end else if (w_hazard) begin
            w_next = S_WAIT;
          end else if (!i_id_advance) begin
            w_next  = S_HELD;
            w_latch = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_HELD: begin
          o_branch_resolved = 1'b1;
          o_branch_taken    = r_taken_held;
          if (i_id_advance || !i_branch_valid) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register and the decision that is held while ID is frozen.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_taken_held <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_taken_held <= w_cond;
    end
  end

  // Statistics. A branch counts only on its resolving cycle, never while held.
  logic [2:0]         w_inc;
  logic [COUNT_W-1:0] r_cnt [3];
  logic               w_resolving;

  assign w_resolving = o_branch_resolved && (r_state != S_HELD);
  assign w_inc[0]    = w_resolving;
  assign w_inc[1]    = w_resolving && o_branch_taken;
  assign w_inc[2]    = o_branch_stall;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      // Saturating counter: it stops at all-ones.
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_cnt[gi] <= '0;
        end else if (w_inc[gi] && (r_cnt[gi] != '1)) begin
          r_cnt[gi] <= r_cnt[gi] + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  assign o_branch_count = r_cnt[0];
  assign o_taken_count  = r_cnt[1];
  assign o_stall_cycles = r_cnt[2];

endmodule
